simon_stream_feeder: RTL and testbench

SIMON_STREAM_FEEDER -- requirements
Module: simon_stream_feeder

---
 rtl/simon_stream_pkg.sv | 13 +
 rtl/simon_block_fifo.sv | 58 +++++
 rtl/simon_stream_feeder.sv | 102 ++++++++++
 tb/tb_simon_stream_feeder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_stream_pkg.sv
// simon_stream_pkg: shared defaults, FSM state types and block type for the SIMON stream feeder
package simon_stream_pkg;

    localparam int N_DEFAULT     = 64;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} issue_state_t;

    typedef enum logic {R_IDLE, R_ACK} read_state_t;

    typedef logic [1:0][N_DEFAULT-1:0] block_t;

endpackage

// File: rtl/simon_block_fifo.sv
// simon_block_fifo: power-of-two block FIFO with first-word-fall-through head and occupancy count
module simon_block_fifo
    import simon_stream_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       R,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [1:0][N-1:0]          i_din,
    output logic [1:0][N-1:0]          o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [1:0][N-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    // storage is data-only; stale entries are unreachable once the pointers reset
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_din;
    end

    // pointers wrap naturally at DEPTH because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (R) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            if (w_push != w_pop)
                r_count <= w_push ? r_count + CW'(1) : r_count - CW'(1);
        end
    end

endmodule

// File: rtl/simon_stream_feeder.sv
// simon_stream_feeder: buffers input blocks into a SIMON core and hands its results downstream
module simon_stream_feeder
    import simon_stream_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       R,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0][N-1:0]          in_block,
    output logic                       newData,
    output logic [1:0][N-1:0]          inData,
    input  logic                       loadData,
    input  logic                       doneData,
    input  logic [1:0][N-1:0]          outData,
    output logic                       readData,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0][N-1:0]          out_block,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    issue_state_t      r_issue;
    read_state_t       r_read;
    logic [1:0][N-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign in_ready = !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_issue == REQ) && loadData;

    simon_block_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .R       (R),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (in_block),
        .o_head  (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // issue path: offer the head, pop on the loadData edge, then wait out the loadData level
    always_ff @(posedge clk) begin
        if (R) begin
            r_issue <= IDLE;
            newData <= 1'b0;
            inData  <= '0;
        end else begin
            case (r_issue)
                IDLE: if (!w_empty) begin
                    inData  <= w_head;
                    newData <= 1'b1;
                    r_issue <= REQ;
                end
                REQ: if (loadData) begin
                    newData <= 1'b0;
                    r_issue <= RELEASE;
                end
                RELEASE: if (!loadData)
                    r_issue <= IDLE;
                default: r_issue <= IDLE;
            endcase
        end
    end

    // read path: take a result only when the output register is free, ack until doneData drops
    always_ff @(posedge clk) begin
        if (R) begin
            r_read    <= R_IDLE;
            readData  <= 1'b0;
            out_valid <= 1'b0;
            out_block <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (r_read)
                R_IDLE: if (doneData && !out_valid) begin
                    out_block <= outData;
                    out_valid <= 1'b1;
                    readData  <= 1'b1;
                    r_read    <= R_ACK;
                end
                R_ACK: if (!doneData) begin
                    readData <= 1'b0;
                    r_read   <= R_IDLE;
                end
                default: r_read <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_stream_feeder.sv
// tb_simon_stream_feeder: directed and randomized checks of the feeder against a queue-based model
module tb_simon_stream_feeder;

    localparam int N     = 64;
    localparam int DEPTH = 4;

    logic              clk       = 1'b0;
    logic              R         = 1'b1;
    logic              in_valid  = 1'b0;
    logic              loadData  = 1'b0;
    logic              doneData  = 1'b0;
    logic              out_ready = 1'b0;
    logic [1:0][N-1:0] in_block  = '0;
    logic [1:0][N-1:0] outData   = '0;
    logic              in_ready;
    logic              newData;
    logic              readData;
    logic              out_valid;
    logic [1:0][N-1:0] inData;
    logic [1:0][N-1:0] out_block;
    logic [2:0]        count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    simon_stream_feeder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .R         (R),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .newData   (newData),
        .inData    (inData),
        .loadData  (loadData),
        .doneData  (doneData),
        .outData   (outData),
        .readData  (readData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .count     (count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // behavioural model: a queue of accepted blocks, an outstanding offer, and one result slot
    logic [127:0] mq[$];
    logic [127:0] m_in  = '0;
    logic [127:0] m_ob  = '0;
    bit           m_new = 1'b0;
    bit           m_rel = 1'b0;
    bit           m_rd  = 1'b0;
    bit           m_ov  = 1'b0;
    bit           m_push;
    bit           m_pop;
    bit           m_ov0;

    initial forever begin
        @(posedge clk);
        if (R) begin
            mq.delete();
            m_new = 1'b0; m_rel = 1'b0; m_rd = 1'b0; m_ov = 1'b0;
            m_in  = '0;   m_ob  = '0;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_pop  = 1'b0;
            if (m_new) begin
                if (loadData) begin
                    m_pop = 1'b1; m_new = 1'b0; m_rel = 1'b1;
                end
            end else if (m_rel) begin
                m_rel = loadData;
            end else if (mq.size() != 0) begin
                m_new = 1'b1; m_in = mq[0];
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(in_block);
            m_ov0 = m_ov;
            if (m_ov0 && out_ready) m_ov = 1'b0;
            if (m_rd) begin
                if (!doneData) m_rd = 1'b0;
            end else if (doneData && !m_ov0) begin
                m_ob = outData; m_ov = 1'b1; m_rd = 1'b1;
            end
        end
    end

    // observed core handshakes and downstream transfers
    logic [127:0] iss[$];
    logic [127:0] rx[$];

    initial forever begin
        @(posedge clk);
        if (!R && newData && loadData) iss.push_back(inData);
        if (!R && out_valid && out_ready) rx.push_back(out_block);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("newData",   newData,   m_new);
            check("inData",    inData,    m_in);
            check("count",     count,     mq.size());
            check("in_ready",  in_ready,  mq.size() < DEPTH);
            check("readData",  readData,  m_rd);
            check("out_valid", out_valid, m_ov);
            check("out_block", out_block, m_ob);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    localparam logic [127:0] B1 = 128'h74206E69206D6F6F6D69732061207369;
    localparam logic [127:0] B2 = 128'hA8D5F7DE0123FEDC01234567FEDCBA98;
    localparam logic [127:0] D1 = 128'h5BC92D014567BA9889ABCDEF01234567;
    localparam logic [127:0] D2 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] D3 = 128'hCAFEF00DDEADBEEF0011223344556677;

    logic [127:0] fl[5];
    logic [127:0] blk[9];

    initial begin
        repeat (3) tick();
        check("rst_newData", newData, 0);
        check("rst_count", count, 0);
        check("rst_readData", readData, 0);
        R = 1'b0;
        chk_en = 1'b1;
        check("in_ready_after_rst", in_ready, 1);

        // single block through the issue path
        in_valid = 1'b1; in_block = B1;
        tick();
        in_valid = 1'b0;
        check("single_count1", count, 1);
        check("single_new_early", newData, 0);
        tick();
        check("single_new", newData, 1);
        check("single_inData", inData, B1);
        tick();
        loadData = 1'b1;
        tick();
        check("single_popped_new", newData, 0);
        check("single_count0", count, 0);
        tick();
        loadData = 1'b0;
        repeat (2) tick();
        check("single_one_pop", iss.size(), 1);
        check("single_idle_new", newData, 0);

        // result path and backpressure
        doneData = 1'b1; outData = D1;
        tick();
        check("res_readData", readData, 1);
        check("res_out_valid", out_valid, 1);
        check("res_out_block", out_block, D1);
        tick();
        check("res_rd_hold", readData, 1);
        doneData = 1'b0;
        tick();
        check("res_rd_fall", readData, 0);
        doneData = 1'b1; outData = D2;
        repeat (2) tick();
        check("bp_rd_low", readData, 0);
        check("bp_block_kept", out_block, D1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ov_clear", out_valid, 0);
        check("bp_rd_still_low", readData, 0);
        tick();
        check("bp_capture", readData, 1);
        check("bp_block2", out_block, D2);
        doneData = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_rx_len", rx.size(), 2);
        check("bp_rx0", rx.size() > 0 ? rx[0] : '0, D1);
        check("bp_rx1", rx.size() > 1 ? rx[1] : '0, D2);
        doneData = 1'b1; outData = D3;
        tick();
        doneData = 1'b0;
        tick();

        // full FIFO rejects the fifth block
        for (int i = 0; i < 5; i++) begin
            fl[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_valid = 1'b1; in_block = fl[i];
            tick();
            if (i == 3) begin
                check("full_in_ready", in_ready, 0);
                check("full_count4", count, 4);
            end
        end
        in_valid = 1'b0;
        check("full_count_final", count, 4);

        // reset in REQ with three blocks queued
        loadData = 1'b1;
        tick();
        loadData = 1'b0;
        repeat (2) tick();
        check("pre_rst_count3", count, 3);
        check("pre_rst_new", newData, 1);
        check("pre_rst_inData", inData, fl[1]);
        R = 1'b1;
        tick();
        check("mid_rst_newData", newData, 0);
        check("mid_rst_readData", readData, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_inData", inData, 0);
        check("mid_rst_out_block", out_block, 0);
        R = 1'b0;
        iss.delete();
        for (int i = 0; i < 6; i++) begin
            loadData = i[0];
            tick();
        end
        loadData = 1'b0;
        check("post_rst_no_issue", iss.size(), 0);
        check("post_rst_newData", newData, 0);

        // nine blocks through a four-deep FIFO with random core latency
        for (int i = 0; i < 9; i++)
            blk[i] = (i == 2) ? B2 : {$urandom(), $urandom(), $urandom(), $urandom()};
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    bit acc;
                    in_valid = 1'b1; in_block = blk[i];
                    for (int w = 0; w < 100; w++) begin
                        @(negedge clk);
                        acc = in_ready;
                        tick();
                        if (acc) break;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                int g = 0;
                while (iss.size() < 9 && g < 600) begin
                    tick();
                    g++;
                    loadData = $urandom_range(0, 2) == 0;
                end
            end
        join
        loadData = 1'b0;
        repeat (4) tick();
        check("stream_len", iss.size(), 9);
        for (int i = 0; i < 9 && i < iss.size(); i++)
            check("stream_order", iss[i], blk[i]);
        check("stream_pos2", iss.size() > 2 ? iss[2] : '0, 128'hA8D5F7DE0123FEDC01234567FEDCBA98);

        // unconstrained random traffic with occasional resets
        repeat (3000) begin
            tick();
            R         = $urandom_range(0, 299) == 0;
            in_valid  = $urandom_range(0, 1) == 1;
            in_block  = {$urandom(), $urandom(), $urandom(), $urandom()};
            loadData  = $urandom_range(0, 2) == 0;
            doneData  = $urandom_range(0, 2) == 0;
            outData   = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready = $urandom_range(0, 1) == 1;
        end
        R = 1'b0;
        repeat (3) tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
